window_feeder: RTL and testbench

- Upstream stage of the single-engine topology: streams the input string from a character memory into a circular window of 2**CC_ID_BITS slots.
- Drives cur_window, cur_window_enable, cur_window_end_of_s and new_char.
- Injects the initial thread (PC 0) through the override channel.
- Slides the window as the engine retires characters, and reports match/no-match.

---
 rtl/window_feeder_pkg.sv | 19 +
 rtl/window_feeder_if.sv | 30 +++
 rtl/window_fetch_unit.sv | 66 ++++++
 rtl/window_feeder.sv | 197 +++++++++++++++++++
 tb/tb_window_feeder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_feeder_pkg.sv
// Shared types and constants for the window feeder: FSM state encoding,
// the string terminator and the program counter of the initial thread.
package window_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    INJECT = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Character value that terminates the input string.
  localparam int EOS_CHAR = 0;

  // Program counter carried by the initial thread injected at the window head.
  localparam int INITIAL_PC = 0;

endpackage

// File: rtl/window_feeder_if.sv
// Character-memory read channel and override-token channel of the window
// feeder. The feeder drives requests and tokens (master); the memory and
// the matching engine answer (slave).
interface window_feeder_if #(
  parameter int CC_ID_BITS      = 1,
  parameter int CHARACTER_WIDTH = 8,
  parameter int PC_WIDTH        = 8,
  parameter int STR_ADDR_WIDTH  = 16
);

  logic [STR_ADDR_WIDTH-1:0]      str_addr;
  logic                           str_valid;
  logic                           str_ready;
  logic [CHARACTER_WIDTH-1:0]     str_data;

  logic                           ovr_valid;
  logic [PC_WIDTH+CC_ID_BITS-1:0] ovr_data;
  logic                           ovr_ready;

  modport master (
    output str_addr, str_valid, ovr_valid, ovr_data,
    input  str_ready, str_data, ovr_ready
  );

  modport slave (
    input  str_addr, str_valid, ovr_valid, ovr_data,
    output str_ready, str_data, ovr_ready
  );

endinterface

// File: rtl/window_fetch_unit.sv
// Fetch side of the window feeder: keeps the slot fill pointer and the
// character read address, raises read requests for empty slots and reports
// each granted character as a slot write to the parent.
module window_fetch_unit
  import window_feeder_pkg::*;
#(
  parameter int CC_ID_BITS     = 1,
  parameter int STR_ADDR_WIDTH = 16,
  localparam int W             = 2**CC_ID_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic [STR_ADDR_WIDTH-1:0] start_addr,
  input  logic                      active,
  input  logic [W-1:0]              slot_enable,
  input  logic                      eos_seen,
  output logic [STR_ADDR_WIDTH-1:0] str_addr,
  output logic                      str_valid,
  input  logic                      str_ready,
  output logic                      wr_en,
  output logic [CC_ID_BITS-1:0]     wr_slot
);

  logic [CC_ID_BITS-1:0]     fill_ptr;
  logic [STR_ADDR_WIDTH-1:0] rd_addr;
  // A request left waiting when the run ends keeps str_valid up until it is
  // granted, so a request is never withdrawn.
  logic                      hold;
  logic                      grant;

  // Raise a request for the slot under the fill pointer while it is empty
  always_comb begin
    if (hold) begin
      str_valid = 1'b1;
    end else if (active && !eos_seen && !slot_enable[fill_ptr]) begin
      str_valid = 1'b1;
    end else begin
      str_valid = 1'b0;
    end
    grant    = str_valid && str_ready;
    wr_en    = grant && active;
    wr_slot  = fill_ptr;
    str_addr = rd_addr;
  end

  // Advance pointer and address on each grant; remember an ungranted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_ptr <= {CC_ID_BITS{1'b0}};
      rd_addr  <= {STR_ADDR_WIDTH{1'b0}};
      hold     <= 1'b0;
    end else if (restart) begin
      fill_ptr <= {CC_ID_BITS{1'b0}};
      rd_addr  <= start_addr;
      hold     <= 1'b0;
    end else if (grant) begin
      fill_ptr <= fill_ptr + CC_ID_BITS'(1);
      rd_addr  <= rd_addr + STR_ADDR_WIDTH'(1);
      hold     <= 1'b0;
    end else begin
      hold     <= str_valid;
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Window feeder: streams a zero-terminated string into a circular window of
// 2**CC_ID_BITS slots, injects the initial thread at the window head,
// slides the window as the engine retires characters and reports the
// match result.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int CC_ID_BITS      = 1,
  parameter int CHARACTER_WIDTH = 8,
  parameter int PC_WIDTH        = 8,
  parameter int STR_ADDR_WIDTH  = 16,
  localparam int W              = 2**CC_ID_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [STR_ADDR_WIDTH-1:0]    start_addr,
  window_feeder_if.master              bus,
  output logic [W*CHARACTER_WIDTH-1:0] cur_window,
  output logic [W-1:0]                 cur_window_enable,
  output logic [W-1:0]                 cur_window_end_of_s,
  output logic                         new_char,
  input  logic [W-1:0]                 elaborating_chars,
  input  logic                         any_bb_accept,
  input  logic                         any_bb_running,
  output logic                         busy,
  output logic                         done,
  output logic                         accepted,
  output logic [31:0]                  chars_consumed
);

  state_t                state;
  state_t                next_state;
  logic [CC_ID_BITS-1:0] head;
  logic [CC_ID_BITS-1:0] head_next;
  logic                  eos_seen;
  // The engine picks the token up one cycle after the handshake; idleness is
  // judged only once that cycle has passed.
  logic                  token_seen;
  logic                  start_ok;
  logic                  fetch_active;
  logic                  wr_en;
  logic [CC_ID_BITS-1:0] wr_slot;
  logic                  wr_is_eos;
  logic [W-1:0]          wr_mask;
  logic [W-1:0]          slide_mask;
  logic                  slide_ok;
  logic                  slide;
  logic                  set_accept;

  window_fetch_unit #(
    .CC_ID_BITS     (CC_ID_BITS),
    .STR_ADDR_WIDTH (STR_ADDR_WIDTH)
  ) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .restart     (start_ok),
    .start_addr  (start_addr),
    .active      (fetch_active),
    .slot_enable (cur_window_enable),
    .eos_seen    (eos_seen),
    .str_addr    (bus.str_addr),
    .str_valid   (bus.str_valid),
    .str_ready   (bus.str_ready),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot)
  );

  // Qualify start, decode the slot write and evaluate the slide condition
  always_comb begin
    start_ok     = start && ((state == IDLE) || (state == DONE));
    fetch_active = (state == FILL) || (state == RUN);
    head_next    = head + CC_ID_BITS'(1);
    wr_is_eos    = (bus.str_data == CHARACTER_WIDTH'(EOS_CHAR));
    wr_mask      = {W{1'b0}};
    if (wr_en) begin
      wr_mask[wr_slot] = 1'b1;
    end else begin
      wr_mask = {W{1'b0}};
    end
    slide_ok = cur_window_enable[head] && !cur_window_end_of_s[head] &&
               !elaborating_chars[head] &&
               (cur_window_enable[head_next] || eos_seen);
  end

  // Next-state logic with RUN priority: accept, then no-thread, then slide
  always_comb begin
    next_state = state;
    slide      = 1'b0;
    set_accept = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) next_state = FILL;
        else          next_state = IDLE;
      end
      FILL: begin
        // Look at the slot being written this cycle so the token follows
        // the last fill grant by one cycle.
        if ((&(cur_window_enable | wr_mask)) || eos_seen || (wr_en && wr_is_eos))
          next_state = INJECT;
        else
          next_state = FILL;
      end
      INJECT: begin
        if (bus.ovr_ready) next_state = RUN;
        else               next_state = INJECT;
      end
      RUN: begin
        if (any_bb_accept) begin
          next_state = DONE;
          set_accept = 1'b1;
        end else if ((elaborating_chars == {W{1'b0}}) && !any_bb_running && token_seen) begin
          next_state = DONE;
        end else if (slide_ok) begin
          next_state = RUN;
          slide      = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (start_ok) next_state = FILL;
        else          next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
    slide_mask = {W{1'b0}};
    if (slide) begin
      slide_mask[head] = 1'b1;
    end else begin
      slide_mask = {W{1'b0}};
    end
  end

  // Window slot storage: writes from the fetch unit, clears from slides
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_window          <= {(W*CHARACTER_WIDTH){1'b0}};
      cur_window_enable   <= {W{1'b0}};
      cur_window_end_of_s <= {W{1'b0}};
    end else if (start_ok) begin
      cur_window_enable   <= {W{1'b0}};
      cur_window_end_of_s <= {W{1'b0}};
    end else begin
      cur_window_enable   <= (cur_window_enable & ~slide_mask) | wr_mask;
      cur_window_end_of_s <= (cur_window_end_of_s & ~wr_mask) |
                             (wr_is_eos ? wr_mask : {W{1'b0}});
      for (int i = 0; i < W; i++) begin
        if (wr_mask[i]) cur_window[i*CHARACTER_WIDTH +: CHARACTER_WIDTH] <= bus.str_data;
      end
    end
  end

  // FSM state, run bookkeeping and registered status/token outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      head           <= {CC_ID_BITS{1'b0}};
      eos_seen       <= 1'b0;
      token_seen     <= 1'b0;
      accepted       <= 1'b0;
      chars_consumed <= 32'd0;
      new_char       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.ovr_valid  <= 1'b0;
      bus.ovr_data   <= {(PC_WIDTH+CC_ID_BITS){1'b0}};
    end else begin
      state    <= next_state;
      new_char <= slide;
      busy     <= (next_state == FILL) || (next_state == INJECT) || (next_state == RUN);
      done     <= (next_state == DONE);
      if (next_state == INJECT) begin
        bus.ovr_valid <= 1'b1;
        bus.ovr_data  <= {head, PC_WIDTH'(INITIAL_PC)};
      end else begin
        bus.ovr_valid <= 1'b0;
        bus.ovr_data  <= {(PC_WIDTH+CC_ID_BITS){1'b0}};
      end
      if (start_ok) begin
        head           <= {CC_ID_BITS{1'b0}};
        eos_seen       <= 1'b0;
        token_seen     <= 1'b0;
        accepted       <= 1'b0;
        chars_consumed <= 32'd0;
      end else begin
        if (slide) head <= head_next;
        if (wr_en && wr_is_eos) eos_seen <= 1'b1;
        if (state == RUN) token_seen <= 1'b1;
        if (set_accept) accepted <= 1'b1;
        if (slide && (chars_consumed != 32'hFFFF_FFFF))
          chars_consumed <= chars_consumed + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder (W=2): expected reads, tokens and run
// results are queued by the stimulus and checked by a separate monitor.
module tb_window_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'h0000;
  logic [15:0] cur_window;
  logic [1:0]  cur_window_enable;
  logic [1:0]  cur_window_end_of_s;
  logic        new_char;
  logic [1:0]  elab = 2'b00;
  logic        accept = 1'b0;
  logic        running = 1'b0;
  logic        busy;
  logic        done;
  logic        accepted;
  logic [31:0] chars_consumed;

  logic [7:0]  mem [0:255];

  typedef struct packed {
    logic        acc;
    logic [31:0] cons;
  } done_exp_t;

  logic [15:0] exp_addr [$];
  logic [8:0]  exp_ovr [$];
  done_exp_t   exp_done [$];

  int checks = 0;
  int errors = 0;
  int nc_count = 0;
  int nc_before = 0;
  logic done_q = 1'b0;

  window_feeder_if #(.CC_ID_BITS(1), .CHARACTER_WIDTH(8), .PC_WIDTH(8),
                     .STR_ADDR_WIDTH(16)) bus ();

  assign bus.str_data = mem[bus.str_addr[7:0]];

  window_feeder #(.CC_ID_BITS(1), .CHARACTER_WIDTH(8), .PC_WIDTH(8),
                  .STR_ADDR_WIDTH(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .start_addr          (start_addr),
    .bus                 (bus),
    .cur_window          (cur_window),
    .cur_window_enable   (cur_window_enable),
    .cur_window_end_of_s (cur_window_end_of_s),
    .new_char            (new_char),
    .elaborating_chars   (elab),
    .any_bb_accept       (accept),
    .any_bb_running      (running),
    .busy                (busy),
    .done                (done),
    .accepted            (accepted),
    .chars_consumed      (chars_consumed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_str_valid"}, 64'(bus.str_valid), 64'd0);
    check({tag, "_str_addr"}, 64'(bus.str_addr), 64'd0);
    check({tag, "_ovr_valid"}, 64'(bus.ovr_valid), 64'd0);
    check({tag, "_ovr_data"}, 64'(bus.ovr_data), 64'd0);
    check({tag, "_window"}, 64'(cur_window), 64'd0);
    check({tag, "_enable"}, 64'(cur_window_enable), 64'd0);
    check({tag, "_eos"}, 64'(cur_window_end_of_s), 64'd0);
    check({tag, "_status"}, 64'({new_char, busy, done, accepted}), 64'd0);
    check({tag, "_chars"}, 64'(chars_consumed), 64'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, n);
    end
  endtask

  // Monitor: compares every read grant, token handshake and run completion
  always @(negedge clk) begin
    if (rst) begin
      if (bus.str_valid && bus.str_ready) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0h, required no read", bus.str_addr);
        end else begin
          check("read_addr", 64'(bus.str_addr), 64'(exp_addr.pop_front()));
        end
      end
      if (bus.ovr_valid && bus.ovr_ready) begin
        if (exp_ovr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_token: data %0h, required no token", bus.ovr_data);
        end else begin
          check("ovr_data", 64'(bus.ovr_data), 64'(exp_ovr.pop_front()));
        end
      end
      if (done && !done_q) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: accepted %0b, required no completion", accepted);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          check("done_accepted", 64'(accepted), 64'(e.acc));
          check("done_chars", 64'(chars_consumed), 64'(e.cons));
          check("done_busy", 64'(busy), 64'd0);
        end
      end
      if (new_char) nc_count++;
    end
    done_q = done;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h61; mem[8'h11] = 8'h62; mem[8'h12] = 8'h00;
    mem[8'h20] = 8'h78; mem[8'h21] = 8'h00;
    mem[8'h30] = 8'h00;
    mem[8'h40] = 8'h70; mem[8'h41] = 8'h71; mem[8'h42] = 8'h00;
    bus.str_ready = 1'b1;
    bus.ovr_ready = 1'b1;

    // Reset state
    tick(); tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // Test 1: "ab\0", single slide, then accept against a live slide
    elab = 2'b01; running = 1'b1;
    exp_addr.push_back(16'h0010); exp_addr.push_back(16'h0011);
    exp_addr.push_back(16'h0012);
    exp_ovr.push_back(9'h000);
    exp_done.push_back('{acc: 1'b1, cons: 32'd1});
    start = 1'b1; start_addr = 16'h0010;
    tick();
    start = 1'b0;
    check("t1_first_valid", 64'(bus.str_valid), 64'd1);
    check("t1_first_addr", 64'(bus.str_addr), 64'h10);
    tick(); tick();
    check("t1_ovr_valid", 64'(bus.ovr_valid), 64'd1);
    check("t1_window", 64'(cur_window), 64'h6261);
    check("t1_enable", 64'(cur_window_enable), 64'h3);
    tick(); tick(); tick(); tick();
    check("t1_no_slide_yet", 64'(nc_count), 64'd0);
    elab = 2'b10;
    tick();
    check("t1_new_char", 64'(new_char), 64'd1);
    check("t1_chars", 64'(chars_consumed), 64'd1);
    check("t1_enable_slid", 64'(cur_window_enable), 64'h2);
    tick();
    check("t1_refetch_enable", 64'(cur_window_enable), 64'h3);
    check("t1_refetch_eos", 64'(cur_window_end_of_s), 64'h1);
    check("t1_refetch_window", 64'(cur_window), 64'h6200);
    tick(); tick();
    check("t1_one_pulse", 64'(nc_count), 64'd1);
    elab = 2'b00; accept = 1'b1;
    tick();
    accept = 1'b0;
    check("t1_accept_no_pulse", 64'(new_char), 64'd0);
    check("t1_done", 64'({done, accepted}), 64'h3);
    wait_done("t1");
    tick();

    // Test 2/4: backpressure on both channels, then idle engine, eos in slot 1
    running = 1'b0; elab = 2'b00;
    bus.str_ready = 1'b0; bus.ovr_ready = 1'b0;
    nc_before = nc_count;
    exp_addr.push_back(16'h0020); exp_addr.push_back(16'h0021);
    exp_ovr.push_back(9'h000);
    exp_done.push_back('{acc: 1'b0, cons: 32'd1});
    start = 1'b1; start_addr = 16'h0020;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 64'(bus.str_valid), 64'd1);
      check("t2_stall_addr", 64'(bus.str_addr), 64'h20);
      tick();
    end
    check("t2_stall_no_write", 64'(cur_window_enable), 64'h0);
    bus.str_ready = 1'b1;
    tick();
    check("t2_one_write", 64'(cur_window_enable), 64'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_ovr_hold_valid", 64'(bus.ovr_valid), 64'd1);
      check("t2_ovr_hold_data", 64'(bus.ovr_data), 64'h000);
      tick();
    end
    bus.ovr_ready = 1'b1;
    wait_done("t4");
    check("t4_one_slide", 64'(nc_count - nc_before), 64'd1);
    check("t4_enable", 64'(cur_window_enable), 64'h2);
    check("t4_eos", 64'(cur_window_end_of_s), 64'h2);
    tick();

    // Test 5: empty string, start during RUN ignored
    running = 1'b1;
    exp_addr.push_back(16'h0030);
    exp_ovr.push_back(9'h000);
    exp_done.push_back('{acc: 1'b0, cons: 32'd0});
    start = 1'b1; start_addr = 16'h0030;
    tick();
    start = 1'b0;
    tick();
    check("t5_enable", 64'(cur_window_enable), 64'h1);
    check("t5_eos", 64'(cur_window_end_of_s), 64'h1);
    check("t5_ovr_valid", 64'(bus.ovr_valid), 64'd1);
    tick();
    start = 1'b1; start_addr = 16'h0010;
    tick();
    start = 1'b0;
    check("t5_ignored_busy", 64'({busy, done}), 64'h2);
    check("t5_ignored_fetch", 64'(bus.str_valid), 64'd0);
    running = 1'b0;
    wait_done("t5");
    tick();

    // Test 6: reset mid-RUN with a read pending, then clean restart
    elab = 2'b01; running = 1'b1;
    exp_addr.push_back(16'h0040); exp_addr.push_back(16'h0041);
    exp_ovr.push_back(9'h000);
    start = 1'b1; start_addr = 16'h0040;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    bus.str_ready = 1'b0; elab = 2'b00;
    tick();
    check("t6_pending_valid", 64'(bus.str_valid), 64'd1);
    check("t6_pending_addr", 64'(bus.str_addr), 64'h42);
    #2;
    rst = 1'b0;
    #1;
    check_zero("t6_async");
    tick(); tick();
    rst = 1'b1;
    bus.str_ready = 1'b1; running = 1'b0;
    tick();
    exp_addr.push_back(16'h0040); exp_addr.push_back(16'h0041);
    exp_addr.push_back(16'h0042);
    exp_ovr.push_back(9'h000);
    exp_done.push_back('{acc: 1'b0, cons: 32'd1});
    start = 1'b1; start_addr = 16'h0040;
    tick();
    start = 1'b0;
    check("t6_restart_addr", 64'(bus.str_addr), 64'h40);
    wait_done("t6");
    tick();

    check("left_reads", 64'(exp_addr.size()), 64'd0);
    check("left_tokens", 64'(exp_ovr.size()), 64'd0);
    check("left_runs", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
